// File: rtl/ysyx_24120013_pkg.sv
// Shared RV32I decode definitions: opcodes, command codes and immediate formats
// for the ysyx_24120013 decode stage.
package ysyx_24120013_pkg;

  localparam int CMD_W = 4;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP     = 4'd0,
    CMD_OP_IMM  = 4'd1,
    CMD_OP      = 4'd2,
    CMD_LUI     = 4'd3,
    CMD_AUIPC   = 4'd4,
    CMD_JAL     = 4'd5,
    CMD_JALR    = 4'd6,
    CMD_BRANCH  = 4'd7,
    CMD_LOAD    = 4'd8,
    CMD_STORE   = 4'd9,
    CMD_EBREAK  = 4'd10,
    CMD_ILLEGAL = 4'd15
  } cmd_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  // Only register-producing classes write rd; stores, branches, ebreak and illegal do not.
  function automatic logic cmd_writes_rd(input cmd_e cmd);
    case (cmd)
      CMD_OP_IMM, CMD_OP, CMD_LUI, CMD_AUIPC,
      CMD_JAL, CMD_JALR, CMD_LOAD: return 1'b1;
      default:                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_24120013_idu_pipe_if.sv
// Fetch-side, register-file and execute-side signals of the decode stage.
// master = surrounding pipeline, slave = decode stage.
interface ysyx_24120013_idu_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CMD_WIDTH  = 4
);

  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_inst;
  logic [DATA_WIDTH-1:0] in_pc;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [DATA_WIDTH-1:0] rdata1;
  logic [DATA_WIDTH-1:0] rdata2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_pc;
  logic [DATA_WIDTH-1:0] out_src1;
  logic [DATA_WIDTH-1:0] out_src2;
  logic [ADDR_WIDTH-1:0] out_rd;
  logic                  out_wen;
  logic [31:0]           out_imm;
  logic [CMD_WIDTH-1:0]  out_cmd;
  logic                  out_illegal;
  logic                  halt;

  modport master (
    output in_valid, in_inst, in_pc, rdata1, rdata2, out_ready,
    input  in_ready, raddr1, raddr2, out_valid, out_pc, out_src1, out_src2,
           out_rd, out_wen, out_imm, out_cmd, out_illegal, halt
  );

  modport slave (
    input  in_valid, in_inst, in_pc, rdata1, rdata2, out_ready,
    output in_ready, raddr1, raddr2, out_valid, out_pc, out_src1, out_src2,
           out_rd, out_wen, out_imm, out_cmd, out_illegal, halt
  );

endinterface

// File: rtl/ysyx_24120013_imm_gen.sv
// Combinational RV32I immediate generator; every format sign-extends from inst[31].
module ysyx_24120013_imm_gen
  import ysyx_24120013_pkg::*;
(
  input  logic [31:0] inst,
  input  imm_type_e   imm_type,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate fields for the selected format
  always_comb begin
    imm = 32'd0;
    case (imm_type)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'd0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_24120013_idu_pipe.sv
// Registered RV32I decode stage: opcode classifier, one-entry valid/ready output
// register and a sticky halt raised by an accepted ebreak.
module ysyx_24120013_idu_pipe
  import ysyx_24120013_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CMD_WIDTH  = 4
) (
  input logic                     clk,
  input logic                     rst,
  ysyx_24120013_idu_pipe_if.slave bus
);

  cmd_e                  cmd_s;
  imm_type_e             imm_type_s;
  logic [31:0]           imm_s;
  logic                  wen_s;
  logic                  accept_s;

  logic                  out_valid_r;
  logic                  halt_r;
  logic [DATA_WIDTH-1:0] out_pc_r;
  logic [DATA_WIDTH-1:0] out_src1_r;
  logic [DATA_WIDTH-1:0] out_src2_r;
  logic [ADDR_WIDTH-1:0] out_rd_r;
  logic                  out_wen_r;
  logic [31:0]           out_imm_r;
  logic [CMD_WIDTH-1:0]  out_cmd_r;
  logic                  out_illegal_r;

  assign bus.raddr1 = ADDR_WIDTH'(bus.in_inst[19:15]);
  assign bus.raddr2 = ADDR_WIDTH'(bus.in_inst[24:20]);

  assign bus.in_ready = !halt_r && (!out_valid_r || bus.out_ready);
  assign accept_s     = bus.in_valid && bus.in_ready;

  // Classify the opcode into a command and pick its immediate format
  always_comb begin
    cmd_s      = CMD_ILLEGAL;
    imm_type_s = IMM_NONE;
    if (bus.in_inst == INST_EBREAK) begin
      cmd_s = CMD_EBREAK;
    end else begin
      case (bus.in_inst[6:0])
        OPC_OP_IMM: begin cmd_s = CMD_OP_IMM; imm_type_s = IMM_I; end
        OPC_OP:     begin cmd_s = CMD_OP;     imm_type_s = IMM_NONE; end
        OPC_LUI:    begin cmd_s = CMD_LUI;    imm_type_s = IMM_U; end
        OPC_AUIPC:  begin cmd_s = CMD_AUIPC;  imm_type_s = IMM_U; end
        OPC_JAL:    begin cmd_s = CMD_JAL;    imm_type_s = IMM_J; end
        OPC_JALR:   begin cmd_s = CMD_JALR;   imm_type_s = IMM_I; end
        OPC_BRANCH: begin cmd_s = CMD_BRANCH; imm_type_s = IMM_B; end
        OPC_LOAD:   begin cmd_s = CMD_LOAD;   imm_type_s = IMM_I; end
        OPC_STORE:  begin cmd_s = CMD_STORE;  imm_type_s = IMM_S; end
        default:    begin cmd_s = CMD_ILLEGAL; imm_type_s = IMM_NONE; end
      endcase
    end
  end

  assign wen_s = cmd_writes_rd(cmd_s);

  ysyx_24120013_imm_gen u_imm_gen (
    .inst     (bus.in_inst),
    .imm_type (imm_type_s),
    .imm      (imm_s)
  );

  // Output register: load on accept, drop valid once drained, otherwise hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r   <= 1'b0;
      halt_r        <= 1'b0;
      out_pc_r      <= {DATA_WIDTH{1'b0}};
      out_src1_r    <= {DATA_WIDTH{1'b0}};
      out_src2_r    <= {DATA_WIDTH{1'b0}};
      out_rd_r      <= {ADDR_WIDTH{1'b0}};
      out_wen_r     <= 1'b0;
      out_imm_r     <= 32'd0;
      out_cmd_r     <= {CMD_WIDTH{1'b0}};
      out_illegal_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r   <= 1'b1;
      halt_r        <= halt_r || (cmd_s == CMD_EBREAK);
      out_pc_r      <= bus.in_pc;
      out_src1_r    <= bus.rdata1;
      out_src2_r    <= bus.rdata2;
      out_rd_r      <= wen_s ? ADDR_WIDTH'(bus.in_inst[11:7]) : {ADDR_WIDTH{1'b0}};
      out_wen_r     <= wen_s;
      out_imm_r     <= imm_s;
      out_cmd_r     <= CMD_WIDTH'(cmd_s);
      out_illegal_r <= (cmd_s == CMD_ILLEGAL);
    end else if (bus.out_ready) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.halt        = halt_r;
  assign bus.out_pc      = out_pc_r;
  assign bus.out_src1    = out_src1_r;
  assign bus.out_src2    = out_src2_r;
  assign bus.out_rd      = out_rd_r;
  assign bus.out_wen     = out_wen_r;
  assign bus.out_imm     = out_imm_r;
  assign bus.out_cmd     = out_cmd_r;
  assign bus.out_illegal = out_illegal_r;

endmodule

// File: doc/ysyx_24120013_idu_pipe.md
# ysyx_24120013_idu_pipe

Registered, handshaked RV32I instruction decode stage. It sits between the fetch stage and the execute stage, and replaces the purely combinational decoder. It decodes every base opcode class and generates I/S/B/U/J immediates. It holds one decoded instruction in an output register with valid/ready back-pressure, flags illegal encodings, and latches a sticky halt on `ebreak`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: register/PC data width.
- `ADDR_WIDTH`, 5: register index width.
- `CMD_WIDTH`, 4: width of the command field. Must be ≥ 4.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  fetch presents `in_inst`/`in_pc`.
- `in_ready`  out  1  stage can accept this cycle.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  DATA_WIDTH  PC of `in_inst`.
- `raddr1`, `raddr2`  out  ADDR_WIDTH  register-file read indices: `in_inst[19:15]`, `in_inst[24:20]`.
- `rdata1`, `rdata2`  in  DATA_WIDTH  register-file read data for the same cycle.
- `out_valid`  out  1  decoded payload valid.
- `out_ready`  in  1  execute accepts the payload.
- `out_pc`  out  DATA_WIDTH  PC of the decoded instruction.
- `out_src1`, `out_src2`  out  DATA_WIDTH  operands captured at accept.
- `out_rd`  out  ADDR_WIDTH  destination index. Forced to 0 when `out_wen`=0.
- `out_wen`  out  1  instruction writes `rd`.
- `out_imm`  out  32  sign-extended immediate.
- `out_cmd`  out  CMD_WIDTH  command code.
- `out_illegal`  out  1  unknown encoding.
- `halt`  out  1  sticky; set by an accepted `ebreak`.

## Operation
- Accept: `in_valid && in_ready`. `in_ready = !halt && (!out_valid || out_ready)`.
- On accept, all `out_*` payload registers load the decode of `in_inst`, plus `rdata1`/`rdata2`, and `out_valid` is set to 1.
- If there is no accept and `out_ready`=1, `out_valid` is cleared. Otherwise the payload holds.
- Command codes:
  - 0 NOP
  - 1 OP_IMM (0010011)
  - 2 OP (0110011)
  - 3 LUI (0110111)
  - 4 AUIPC (0010111)
  - 5 JAL (1101111)
  - 6 JALR (1100111)
  - 7 BRANCH (1100011)
  - 8 LOAD (0000011)
  - 9 STORE (0100011)
  - 10 EBREAK (exactly 0x00100073)
  - 15 ILLEGAL (any other encoding)
- `out_wen`=1 for codes 1–6 and 8. It is 0 for all other codes.
- Immediate selection:
  - I-type: OP_IMM, JALR, LOAD.
  - S-type: STORE.
  - B-type: BRANCH, bit 0 = 0.
  - U-type: LUI, AUIPC, low 12 bits = 0.
  - J-type: JAL, bit 0 = 0.
  - All other codes: 0.
  - All immediates sign-extend from `inst[31]`.
- ILLEGAL sets `out_illegal`=1 and `out_wen`=0. It does not halt.
- EBREAK passes downstream as a normal payload. `halt` rises on the edge that accepts it, and `in_ready` is 0 from then until reset.
- `funct3`/`funct7` are not decoded here; execute decodes them. Hazards and forwarding are not handled; upstream guarantees `rdata` is current.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput is 1 instruction/cycle when `out_ready`=1.
- `raddr1`/`raddr2` are combinational from `in_inst`. The register file read is combinational and is sampled at the accept edge.
- Accept and drain in the same cycle: the payload is replaced and `out_valid` stays 1. No bubble and no loss.
- Back-pressure: while `out_valid && !out_ready`, all `out_*` signals are stable and `in_ready`=0.
- Reset (asynchronous assert, any cycle including mid-handshake): `out_valid`=0, `halt`=0, all payload registers 0 (`out_cmd`=0). Any held instruction is dropped. `in_ready`=1 in the first cycle after deassert.
- `halt` does not clear `out_valid`. The EBREAK payload still drains.

## Structure
- Shared package `ysyx_24120013_pkg` holds the opcode constants, the command codes (enum, CMD_WIDTH-wide), and the immediate-type encoding (NONE/I/S/B/U/J).
- Sub-module `ysyx_24120013_imm_gen`: purely combinational; takes inst and imm-type, returns the 32-bit immediate.
- The top module contains the opcode classifier, the handshake/output register, and the halt flop.

## Test plan
- `addi x1,x2,-1` (0xFFF10093), `rdata1`=5, `out_ready`=1 → `raddr1`=2. Next cycle: `out_valid`=1, `out_cmd`=1, `out_imm`=0xFFFFFFFF, `out_rd`=1, `out_wen`=1, `out_src1`=5.
- Immediate types:
  - `sw x5,8(x2)` (0x00512423) → `out_cmd`=9, `out_imm`=8, `out_wen`=0, `out_rd`=0.
  - `beq x0,x0,-4` (0xFE000EE3) → `out_cmd`=7, `out_imm`=0xFFFFFFFC.
  - `lui x3,0x12345` (0x123451B7) → `out_cmd`=3, `out_imm`=0x12345000.
- Back-pressure: accept A, then hold `out_ready`=0 for 3 cycles while B is valid → `in_ready`=0, A payload stable. Release → A then B delivered in order, no duplicates.
- Streaming: 8 back-to-back instructions with `out_ready`=1 → 8 payloads on 8 consecutive cycles.
- Halt and illegal:
  - `ebreak` (0x00100073) followed by `addi` → `halt`=1 after the accept edge, EBREAK payload (`out_cmd`=10) delivered, `addi` never accepted.
  - Assert `rst`=0 → `halt`=0, `out_valid`=0.
  - 0x00000000 → `out_cmd`=15, `out_illegal`=1, `halt` stays 0.
